// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM type and sizing helpers for sram_burst_ctrl
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned BASE_DEFAULT = 1024;

    function automatic int unsigned hpw(input int unsigned word_w, input int unsigned dq_w);
        return word_w / dq_w;
    endfunction

    function automatic int unsigned beats(input int unsigned burst, input int unsigned word_w,
                                          input int unsigned dq_w);
        return burst * hpw(word_w, dq_w);
    endfunction

    // Counters need at least one bit even when they only ever hold zero.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_write_buffer.sv
// rtl/sram_write_buffer.sv - one-entry posted-write buffer (SRAM address, word, valid)
module sram_write_buffer #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [WORD_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (push_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - burst-read / word-write SRAM controller with wait states
// Optional posted-write buffer enabled by SRAM_WRITE_BUFFER_EN.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DQ_W   = 16,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BURST  = 2,
    parameter int unsigned WAIT   = 1,
    parameter int unsigned BASE   = BASE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             req_addr,
    input  logic                    req_rd,
    input  logic                    req_wr,
    input  logic [WORD_W-1:0]       req_wdata,
    output logic [BURST*WORD_W-1:0] rd_data,
    output logic                    ready,
    output logic                    busy,
    inout  wire  [DQ_W-1:0]         SRAM_DQ,
    output logic [ADDR_W-1:0]       SRAM_ADDR,
    output logic                    SRAM_WE_N
);

    localparam int unsigned HPW    = hpw(WORD_W, DQ_W);
    localparam int unsigned BEATS  = beats(BURST, WORD_W, DQ_W);
    localparam int unsigned BEAT_W = cnt_w(BEATS);
    localparam int unsigned WAIT_W = cnt_w(WAIT + 1);
    localparam int unsigned BSH    = $clog2(DQ_W / 8);

    localparam logic [WAIT_W-1:0] WAIT_L  = WAIT_W'(WAIT);
    localparam logic [BEAT_W-1:0] RD_LAST = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] WR_LAST = BEAT_W'(HPW - 1);
    localparam logic [ADDR_W-1:0] BEATS_A = ADDR_W'(BEATS);

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [WORD_W-1:0]         wdata_q, wdata_d;
    logic [BURST*WORD_W-1:0]   rdata_q, rdata_d;

    logic [31:0]               off;
    logic [ADDR_W-1:0]         sa_w;
    logic [ADDR_W-1:0]         sa_rd;
    logic [WORD_W-1:0]         wr_shift;
    logic                      access_end;

    // Addresses below BASE wrap silently through the unsigned subtraction.
    assign off   = req_addr - 32'(BASE);
    assign sa_w  = ADDR_W'(off >> BSH);
    assign sa_rd = sa_w - (sa_w % BEATS_A);

    assign access_end = (wait_q == WAIT_L);
    assign wr_shift   = wdata_q >> (DQ_W * beat_q);

`ifdef SRAM_WRITE_BUFFER_EN
    logic              wb_push, wb_pop, wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [WORD_W-1:0] wb_data;

    sram_write_buffer #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) u_wbuf (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (wb_push),
        .addr_i (sa_w),
        .data_i (req_wdata),
        .pop_i  (wb_pop),
        .valid_o(wb_valid),
        .addr_o (wb_addr),
        .data_o (wb_data)
    );
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_WRITE_BUFFER_EN
        wb_push = 1'b0;
        wb_pop  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                wait_d = '0;
                beat_d = '0;
`ifdef SRAM_WRITE_BUFFER_EN
                // A pending write always drains first so reads see it.
                if (wb_valid) begin
                    state_d = WR;
                    addr_d  = wb_addr;
                    wdata_d = wb_data;
                end else if (req_wr) begin
                    wb_push = 1'b1;
                    state_d = DONE;
                end else if (req_rd) begin
                    state_d = RD;
                    addr_d  = sa_rd;
                end
`else
                if (req_wr) begin
                    state_d = WR;
                    addr_d  = sa_w;
                    wdata_d = req_wdata;
                end else if (req_rd) begin
                    state_d = RD;
                    addr_d  = sa_rd;
                end
`endif
            end
            RD: begin
                if (access_end) begin
                    rdata_d[DQ_W*beat_q +: DQ_W] = SRAM_DQ;
                    wait_d = '0;
                    if (beat_q == RD_LAST) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WR: begin
                if (access_end) begin
                    wait_d = '0;
                    if (beat_q == WR_LAST) begin
                        beat_d = '0;
`ifdef SRAM_WRITE_BUFFER_EN
                        // Background drain: the CPU was already acknowledged.
                        state_d = IDLE;
                        wb_pop  = 1'b1;
`else
                        state_d = DONE;
`endif
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready     = (state_q == DONE);
    assign busy      = (req_rd | req_wr) & ~ready;
    assign rd_data   = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = (state_q != WR);
    assign SRAM_DQ   = (state_q == WR) ? wr_shift[DQ_W-1:0] : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - randomized self-checking bench for sram_burst_ctrl
module tb_sram_burst_ctrl;

    localparam int          BASE   = 1024;
    localparam int          WAIT   = 1;
    localparam int          BURST  = 2;
    localparam int          HPW    = 2;
    localparam int          BEATS  = BURST * HPW;
    localparam int unsigned AMASK  = 32'h3FFFF;
    localparam int          RD_LAT = BEATS * (WAIT + 1) + 1;
`ifdef SRAM_WRITE_BUFFER_EN
    localparam int          WR_LAT = 1;
`else
    localparam int          WR_LAT = HPW * (WAIT + 1) + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [63:0] rd_data;
    logic        ready, busy;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;

    logic        req_rd2 = 1'b0;
    logic        req_wr2 = 1'b0;
    logic [31:0] rd_data2;
    logic        ready2, busy2;
    wire  [15:0] dq2;
    logic [17:0] addr2;
    logic        we2_n;

    int n_cmp = 0;
    int n_bad = 0;

    bit [15:0] mem [0:262143];
    bit        wrn [0:262143];
    bit [15:0] ref_mem [int unsigned];

    always #5 clk = ~clk;

    sram_burst_ctrl #(
        .ADDR_W(18), .DQ_W(16), .WORD_W(32), .BURST(BURST), .WAIT(WAIT), .BASE(BASE)
    ) u_dut (
        .clk(clk), .rst(rst), .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr),
        .req_wdata(req_wdata), .rd_data(rd_data), .ready(ready), .busy(busy),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
    );

    sram_burst_ctrl #(
        .ADDR_W(18), .DQ_W(16), .WORD_W(32), .BURST(1), .WAIT(0), .BASE(BASE)
    ) u_dut2 (
        .clk(clk), .rst(rst), .req_addr(req_addr), .req_rd(req_rd2), .req_wr(req_wr2),
        .req_wdata(req_wdata), .rd_data(rd_data2), .ready(ready2), .busy(busy2),
        .SRAM_DQ(dq2), .SRAM_ADDR(addr2), .SRAM_WE_N(we2_n)
    );

    function automatic logic [15:0] pat(input logic [17:0] a);
        case (a)
            18'd4:   return 16'hAAAA;
            18'd5:   return 16'hBBBB;
            18'd6:   return 16'hCCCC;
            18'd7:   return 16'hDDDD;
            default: return (a[15:0] * 16'h9E37) ^ {14'd0, a[17:16]} ^ 16'h5A5A;
        endcase
    endfunction

    // SRAM models stay silent during reset so the DUT's own bus release is visible.
    assign sram_dq = (sram_we_n && rst) ? (wrn[sram_addr] ? mem[sram_addr] : pat(sram_addr)) : 16'hzzzz;
    assign dq2     = (we2_n && rst) ? (addr2[15:0] ^ 16'h3C3C) : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr] <= sram_dq;
            wrn[sram_addr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input int unsigned a);
        logic [17:0] a18;
        a18 = a[17:0];
        return ref_mem.exists(a) ? ref_mem[a] : pat(a18);
    endfunction

    function automatic int unsigned sa_of(input logic [31:0] addr);
        return ((addr - BASE) >> 1) & AMASK;
    endfunction

    function automatic logic [63:0] exp_rd(input logic [31:0] addr);
        int unsigned sa, b;
        logic [63:0] r;
        sa = sa_of(addr);
        b  = sa - (sa % BEATS);
        for (int k = 0; k < BEATS; k++) r[16*k +: 16] = ref_rd((b + k) & AMASK);
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] wd);
        int unsigned sa;
        sa = sa_of(addr);
        for (int k = 0; k < HPW; k++) ref_mem[(sa + k) & AMASK] = wd[16*k +: 16];
    endtask

    task automatic wait_ready(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
            else cyc++;
        end
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int          cyc, nbusy, k;
        bit          seen;
        logic [17:0] ta[$];
        logic [15:0] td[$];
        logic [63:0] exp;
        int unsigned sa;
        exp = exp_rd(addr);
        sa  = sa_of(addr);
        @(posedge clk); #1;
        req_addr = addr; req_rd = rd; req_wr = wr; req_wdata = wd;
        cyc = 0; nbusy = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (!sram_we_n) begin ta.push_back(sram_addr); td.push_back(sram_dq); end
            if (ready) seen = 1'b1;
            else cyc++;
        end
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
`ifdef SRAM_WRITE_BUFFER_EN
        if (wr) begin
            repeat (HPW * (WAIT + 1) + 4) begin
                @(negedge clk);
                if (!sram_we_n) begin ta.push_back(sram_addr); td.push_back(sram_dq); end
            end
        end
`endif
        chk("ready_seen", seen, 1);
        if (!seen) return;
        if (wr) begin
            chk("wr_latency", cyc, WR_LAT);
            chk("wr_busy_cycles", nbusy, WR_LAT);
            chk("wr_we_cycles", ta.size(), HPW * (WAIT + 1));
            for (int i = 0; i < ta.size(); i++) begin
                k = i / (WAIT + 1);
                chk("wr_addr", ta[i], (sa + k) & AMASK);
                chk("wr_dq", td[i], wd[16*k +: 16]);
            end
            ref_write(addr, wd);
        end else begin
            chk("rd_latency", cyc, RD_LAT);
            chk("rd_busy_cycles", nbusy, RD_LAT);
            chk("rd_data", rd_data, exp);
            chk("rd_no_we", ta.size(), 0);
        end
        chk("idle_we_n", sram_we_n, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          seen;
        logic [31:0] a, w;
        int          r;

        repeat (3) @(negedge clk);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_dq_hiz", (sram_dq === 16'hzzzz), 1);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_op(1'b1, 1'b0, 32'd1032, 32'd0);
        chk("plan_rd_1032", rd_data, 64'hDDDDCCCC_BBBBAAAA);
        do_op(1'b1, 1'b0, 32'd1036, 32'd0);
        chk("plan_rd_1036", rd_data, 64'hDDDDCCCC_BBBBAAAA);
        do_op(1'b0, 1'b1, 32'd1028, 32'h12345678);
        do_op(1'b1, 1'b0, 32'd1028, 32'd0);
        do_op(1'b1, 1'b1, 32'd1100, 32'hA5C3_0F1E);
        do_op(1'b1, 1'b0, 32'd1100, 32'd0);

        // Minimum-latency variant: BURST=1, WAIT=0.
        @(posedge clk); #1;
        req_addr = 32'd1032; req_rd2 = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            if (ready2) seen = 1'b1;
            else cyc++;
        end
        @(posedge clk); #1;
        req_rd2 = 1'b0;
        chk("w0_ready_seen", seen, 1);
        chk("w0_latency", cyc, 3);
        chk("w0_rd_data", rd_data2, {16'h0005 ^ 16'h3C3C, 16'h0004 ^ 16'h3C3C});

        // Reset in the middle of a burst.
        do_op(1'b1, 1'b0, 32'd1032, 32'd0);
        @(posedge clk); #1;
        req_addr = 32'd1200; req_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_we_n", sram_we_n, 1);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_dq_hiz", (sram_dq === 16'hzzzz), 1);
        req_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Write immediately followed by a read of the same line.
        a = 32'd1040;
        w = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_addr = a; req_wr = 1'b1; req_wdata = w;
        wait_ready(cyc, seen);
        chk("wtr_wr_seen", seen, 1);
        chk("wtr_wr_latency", cyc, WR_LAT);
        @(posedge clk); #1;
        req_wr = 1'b0; req_rd = 1'b1;
        ref_write(a, w);
        wait_ready(cyc, seen);
        chk("wtr_rd_seen", seen, 1);
        chk("wtr_rd_data", rd_data, exp_rd(a));
        @(posedge clk); #1;
        req_rd = 1'b0;

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            a = (r == 0 || r == 5) ? $urandom : BASE + $urandom_range(0, 4095);
            w = $urandom;
            if (r < 5)      do_op(1'b1, 1'b0, a, w);
            else if (r < 9) do_op(1'b0, 1'b1, a, w);
            else            do_op(1'b1, 1'b1, a, w);
        end
        for (int n = 0; n < 8; n++) do_op(1'b1, 1'b0, BASE + 8 * n, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
